uart_rx_fifo_ctrl: RTL and testbench

Receive buffer stage directly downstream of the 8-bit UART Rx core in the 16550-style UART. Captures each received character with its parity, framing and break flags into a 16550-compatible RX FIFO, or into a 1-deep holding register when FIFO mode is off. Generates the receive-side LSR bits (DR, OE, FIFO error) and the trigger-level and character-timeout interrupt conditions for the register/interrupt block.

---
 rtl/uart_rx_fifo_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive buffer behind the 8-bit UART Rx core.
// - Stores each character with its parity, framing and break flags.
// - Runs as a 16550-style RX FIFO, or as a 1-deep holding register when FIFO mode is off.
// - Produces the receive-side LSR bits and the trigger-level and character-timeout conditions.
module uart_rx_fifo_ctrl #(
    parameter  int DEPTH    = 16,
    parameter  int TO_CHARS = 4,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          brcx16,
    input  logic          rx_d_rdy,
    input  logic [7:0]    rx_d,
    input  logic          rx_pe,
    input  logic          rx_fe,
    input  logic          rx_bi,
    input  int            num_bits,
    input  logic          parity_en,
    input  logic          fifo_en,
    input  logic          fifo_clr,
    input  logic [1:0]    trig_sel,
    input  logic          rd,
    input  logic          lsr_rd,
    output logic [7:0]    dout,
    output logic          dout_pe,
    output logic          dout_fe,
    output logic          dout_bi,
    output logic          data_ready,
    output logic          overrun,
    output logic          fifo_err,
    output logic          trig_itr,
    output logic          timeout_itr,
    output logic [CW-1:0] count
);

    localparam int PW     = $clog2(DEPTH);
    // Longest character is 2 + 8 data + parity = 11 bit times of 16 ticks each.
    localparam int TO_MAX = TO_CHARS * 16 * 11;
    localparam int TW     = $clog2(TO_MAX + 1);

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          new_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   err_cnt;
    logic [CW-1:0]   trig_lvl;
    logic [TW-1:0]   to_cnt;
    logic [TW-1:0]   to_limit;
    logic            rx_d_rdy_q;
    logic            fifo_en_q;
    logic            flush;
    logic            wr_evt;
    logic            full;
    logic            pop;
    logic            accept;
    logic            overwrite;
    logic            ovr_set;
    logic            new_err;
    logic            head_err;

    // Decode this cycle's write, pop, flush and overflow events.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // otherwise synthesis would have to hold the old value in a latch.
        flush     = fifo_clr || (fifo_en != fifo_en_q);
        wr_evt    = rx_d_rdy && !rx_d_rdy_q && !flush;
        full      = fifo_en ? (count == CW'(DEPTH)) : (count != '0);
        pop       = rd && (count != '0) && !flush;
        // A pop in the same clock frees the slot, so a write at full is still taken.
        accept    = wr_evt && (!full || pop);
        ovr_set   = wr_evt && full && !pop;
        overwrite = ovr_set && !fifo_en;
        head      = mem[rd_ptr];
        new_entry = '{bi: rx_bi, fe: rx_fe, pe: rx_pe, d: rx_d};
        new_err   = rx_pe || rx_fe || rx_bi;
        head_err  = head.pe || head.fe || head.bi;
        to_limit  = TW'(TO_CHARS * 16 * (2 + num_bits + int'(parity_en)));
    end

    // Present the head entry and derive the status outputs.
    always_comb begin
        dout       = (count != '0) ? head.d  : '0;
        dout_pe    = (count != '0) ? head.pe : 1'b0;
        dout_fe    = (count != '0) ? head.fe : 1'b0;
        dout_bi    = (count != '0) ? head.bi : 1'b0;
        data_ready = (count != '0);
        fifo_err   = (err_cnt != '0) && fifo_en;
        case (trig_sel)
            2'b00:   trig_lvl = CW'(1);
            2'b01:   trig_lvl = CW'(4);
            2'b10:   trig_lvl = CW'(8);
            default: trig_lvl = CW'(14);
        endcase
        trig_itr   = fifo_en && (count >= trig_lvl);
    end

    // Edge-detect rx_d_rdy and remember fifo_en to spot mode changes.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            rx_d_rdy_q <= 1'b0;
            fifo_en_q  <= 1'b0;
        end else begin
            rx_d_rdy_q <= rx_d_rdy;
            fifo_en_q  <= fifo_en;
        end
    end

    // Character storage; a non-FIFO overwrite replaces the held head entry.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates every read, so
        // stale contents are never visible and the array can map to RAM.
        if (accept) begin
            mem[wr_ptr] <= new_entry;
        end else if (overwrite) begin
            mem[rd_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy and the count of stored entries carrying an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count   <= count + CW'(accept) - CW'(pop);
            err_cnt <= err_cnt + CW'(accept && new_err) + CW'(overwrite && new_err)
                               - CW'(pop && head_err) - CW'(overwrite && head_err);
        end
    end

    // Sticky overrun; a new overrun wins over a simultaneous LSR read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (lsr_rd) begin
            overrun <= 1'b0;
        end
    end

    // Character timeout: count brcx16 ticks of inactivity while data is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_itr <= 1'b0;
        end else if (flush) begin
            to_cnt      <= '0;
            timeout_itr <= 1'b0;
        end else begin
            if (accept || rd || (count == '0)) begin
                to_cnt <= '0;
            end else if (fifo_en && brcx16) begin
                if (to_cnt >= to_limit - TW'(1)) begin
                    to_cnt      <= to_limit;
                    timeout_itr <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
            if (accept || rd) begin
                timeout_itr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: directed scenarios plus a
// randomized run compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH    = 16;
    localparam int TO_CHARS = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          brcx16;
    logic          rx_d_rdy;
    logic [7:0]    rx_d;
    logic          rx_pe;
    logic          rx_fe;
    logic          rx_bi;
    int            num_bits;
    logic          parity_en;
    logic          fifo_en;
    logic          fifo_clr;
    logic [1:0]    trig_sel;
    logic          rd;
    logic          lsr_rd;
    logic [7:0]    dout;
    logic          dout_pe;
    logic          dout_fe;
    logic          dout_bi;
    logic          data_ready;
    logic          overrun;
    logic          fifo_err;
    logic          trig_itr;
    logic          timeout_itr;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state: the buffer is a plain queue of {bi,fe,pe,d}.
    logic [10:0] m_q[$];
    bit          m_prev;
    bit          m_en_q;
    bit          m_ov;
    bit          m_tout;
    int          m_tcnt;

    uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .TO_CHARS(TO_CHARS)) dut (
        .clk(clk), .rst(rst), .brcx16(brcx16), .rx_d_rdy(rx_d_rdy), .rx_d(rx_d),
        .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi), .num_bits(num_bits),
        .parity_en(parity_en), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
        .trig_sel(trig_sel), .rd(rd), .lsr_rd(lsr_rd), .dout(dout),
        .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
        .data_ready(data_ready), .overrun(overrun), .fifo_err(fifo_err),
        .trig_itr(trig_itr), .timeout_itr(timeout_itr), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic int trig_level(logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 14;
        endcase
    endfunction

    function automatic bit m_err();
        foreach (m_q[i]) if (m_q[i][10:8] != 3'b000) return fifo_en;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs presented at this edge.
    task automatic model_step();
        bit flush, wr, acc, ovs;
        int cap, limit, cnt0;
        logic [10:0] ent;
        if (rst) begin
            m_q.delete();
            m_prev = 0; m_en_q = 0; m_ov = 0; m_tout = 0; m_tcnt = 0;
            return;
        end
        cnt0   = m_q.size();
        flush  = fifo_clr || (fifo_en != m_en_q);
        m_en_q = fifo_en;
        wr     = rx_d_rdy && !m_prev;
        m_prev = rx_d_rdy;
        ent    = {rx_bi, rx_fe, rx_pe, rx_d};
        cap    = fifo_en ? DEPTH : 1;
        limit  = TO_CHARS * 16 * (2 + num_bits + int'(parity_en));
        acc    = 0;
        ovs    = 0;
        if (flush) begin
            m_q.delete();
            m_tcnt = 0;
            m_tout = 0;
            if (lsr_rd) m_ov = 0;
        end else begin
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (wr) begin
                if (m_q.size() < cap) begin
                    m_q.push_back(ent);
                    acc = 1;
                end else begin
                    ovs = 1;
                    if (!fifo_en) m_q[0] = ent;
                end
            end
            if (ovs) m_ov = 1;
            else if (lsr_rd) m_ov = 0;
            if (acc || rd) begin
                m_tcnt = 0;
                m_tout = 0;
            end else if (cnt0 == 0) begin
                m_tcnt = 0;
            end else if (fifo_en && brcx16) begin
                m_tcnt++;
                if (m_tcnt >= limit) begin
                    m_tcnt = limit;
                    m_tout = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic fe,
                        input logic bi, input int hold);
        rx_d = d; rx_pe = pe; rx_fe = fe; rx_bi = bi;
        rx_d_rdy = 1'b1;
        repeat (hold) cyc();
        rx_d_rdy = 1'b0;
        rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
        cyc();
    endtask

    task automatic pulse_rd();
        rd = 1'b1; cyc(); rd = 1'b0;
    endtask

    task automatic pulse_lsr_rd();
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
    endtask

    task automatic flush_fifo();
        fifo_clr = 1'b1; cyc(); fifo_clr = 1'b0; cyc();
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst = 1'b1;
        repeat (3) cyc();
        obs = {count, data_ready, overrun, fifo_err, trig_itr, timeout_itr,
               dout_bi, dout_fe, dout_pe, dout};
        checks++;
        if (obs !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
        end
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (count !== '0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty: count=%0d dr=%b expected 0/0", count, data_ready);
        end
    endtask

    task automatic test_basic();
        flush_fifo();
        send(8'h41, 0, 0, 0, 20);
        send(8'h42, 0, 0, 0, 20);
        send(8'h43, 0, 0, 0, 20);
        checks++;
        if (count !== CW'(3) || dout !== 8'h41) begin
            errors++;
            $display("FAIL basic_fill: count=%0d dout=%h expected 3/41", count, dout);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout !== 8'(8'h41 + i)) begin
                errors++;
                $display("FAIL basic_pop%0d: dout=%h expected %h", i, dout, 8'(8'h41 + i));
            end
            pulse_rd();
        end
        cyc();
        checks++;
        if (data_ready !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL basic_drained: dr=%b count=%0d expected 0/0", data_ready, count);
        end
    endtask

    task automatic test_trigger();
        trig_sel = 2'b01;
        flush_fifo();
        for (int i = 0; i < 3; i++) send(8'($urandom), 0, 0, 0, int'($urandom_range(1, 4)));
        checks++;
        if (trig_itr !== 1'b0) begin
            errors++;
            $display("FAIL trig_below: trig_itr=%b expected 0 at count=%0d", trig_itr, count);
        end
        send(8'($urandom), 0, 0, 0, 2);
        checks++;
        if (trig_itr !== 1'b1) begin
            errors++;
            $display("FAIL trig_at_level: trig_itr=%b expected 1 at count=%0d", trig_itr, count);
        end
        pulse_rd();
        checks++;
        if (trig_itr !== 1'b0) begin
            errors++;
            $display("FAIL trig_after_rd: trig_itr=%b expected 0", trig_itr);
        end
        trig_sel = 2'b11;
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d[$];
        flush_fifo();
        pulse_lsr_rd();
        for (int i = 0; i < DEPTH; i++) begin
            exp_d.push_back(8'($urandom_range(0, 8'h98)));
            send(exp_d[i], 0, 0, 0, 1);
        end
        checks++;
        if (count !== CW'(DEPTH) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_full: count=%0d ovr=%b expected %0d/0", count, overrun, DEPTH);
        end
        send(8'h99, 0, 0, 0, 3);
        checks++;
        if (overrun !== 1'b1 || count !== CW'(DEPTH) || dout !== exp_d[0]) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b count=%0d dout=%h expected 1/%0d/%h",
                     overrun, count, dout, DEPTH, exp_d[0]);
        end
        pulse_lsr_rd();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b expected 0", overrun);
        end
        // Pop and write land on the same clock while full.
        rx_d = 8'hA5; rx_d_rdy = 1'b1; rd = 1'b1;
        cyc();
        rd = 1'b0;
        checks++;
        if (count !== CW'(DEPTH) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_rd_wr_full: count=%0d ovr=%b expected %0d/0", count, overrun, DEPTH);
        end
        rx_d_rdy = 1'b0;
        cyc();
        void'(exp_d.pop_front());
        exp_d.push_back(8'hA5);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== exp_d[i]) begin
                errors++;
                $display("FAIL ovr_drain%0d: dout=%h expected %h", i, dout, exp_d[i]);
            end
            pulse_rd();
        end
    endtask

    task automatic test_error_flags();
        flush_fifo();
        send(8'h00, 0, 1, 1, 2);
        send(8'h55, 0, 0, 0, 2);
        checks++;
        if (fifo_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: fifo_err=%b expected 1", fifo_err);
        end
        checks++;
        if ({dout_bi, dout_fe, dout_pe, dout} !== {3'b110, 8'h00}) begin
            errors++;
            $display("FAIL err_head: flags/dout=%b%b%b/%h expected 110/00",
                     dout_bi, dout_fe, dout_pe, dout);
        end
        pulse_rd();
        checks++;
        if (fifo_err !== 1'b0 || dout !== 8'h55 || dout_bi !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: fifo_err=%b dout=%h bi=%b expected 0/55/0",
                     fifo_err, dout, dout_bi);
        end
        pulse_rd();
    endtask

    task automatic test_timeout();
        int ticks;
        num_bits = 8; parity_en = 1'b0;
        flush_fifo();
        send(8'h5A, 0, 0, 0, 1);
        ticks = 0;
        while (ticks < 645) begin
            brcx16 = 1'($urandom_range(0, 1));
            cyc();
            if (brcx16) ticks++;
            checks++;
            if (timeout_itr !== (ticks >= 640)) begin
                errors++;
                $display("FAIL timeout_tick%0d: timeout_itr=%b expected %b",
                         ticks, timeout_itr, ticks >= 640);
            end
        end
        brcx16 = 1'b0;
        pulse_rd();
        checks++;
        if (timeout_itr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rd_clear: timeout_itr=%b expected 0", timeout_itr);
        end
        send(8'h33, 0, 0, 0, 1);
        brcx16 = 1'b1;
        repeat (300) cyc();
        fifo_clr = 1'b1; cyc(); fifo_clr = 1'b0;
        repeat (700) cyc();
        brcx16 = 1'b0;
        checks++;
        if (timeout_itr !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL timeout_flush: timeout_itr=%b count=%0d expected 0/0", timeout_itr, count);
        end
    endtask

    task automatic test_non_fifo();
        pulse_lsr_rd();
        fifo_en = 1'b0;
        cyc();
        send(8'h11, 0, 0, 0, 2);
        send(8'h22, 0, 0, 0, 2);
        checks++;
        if (dout !== 8'h22 || overrun !== 1'b1 || count !== CW'(1) || trig_itr !== 1'b0) begin
            errors++;
            $display("FAIL nonfifo_overwrite: dout=%h ovr=%b count=%0d trig=%b expected 22/1/1/0",
                     dout, overrun, count, trig_itr);
        end
        fifo_en = 1'b1;
        cyc();
        checks++;
        if (count !== '0 || data_ready !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL nonfifo_toggle: count=%0d dr=%b ovr=%b expected 0/0/1",
                     count, data_ready, overrun);
        end
        pulse_lsr_rd();
    endtask

    task automatic test_random();
        logic [20:0] obs, exp;
        int n;
        num_bits = 5; parity_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rx_d_rdy = ~rx_d_rdy;
            rx_d      = 8'($urandom);
            rx_pe     = ($urandom_range(0, 9) == 0);
            rx_fe     = ($urandom_range(0, 9) == 0);
            rx_bi     = ($urandom_range(0, 19) == 0);
            rd        = ($urandom_range(0, 99) < ((i < 1500) ? 20 : 40));
            lsr_rd    = ($urandom_range(0, 9) == 0);
            fifo_clr  = ($urandom_range(0, 199) == 0);
            brcx16    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) trig_sel = 2'($urandom);
            if ($urandom_range(0, 299) == 0) fifo_en = ~fifo_en;
            cyc();
            n   = m_q.size();
            exp = {CW'(n), n != 0, m_ov, m_err(),
                   fifo_en && (n >= trig_level(trig_sel)), m_tout,
                   (n != 0) ? m_q[0] : 11'h0};
            obs = {count, data_ready, overrun, fifo_err, trig_itr, timeout_itr,
                   dout_bi, dout_fe, dout_pe, dout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp);
            end
        end
        rx_d_rdy = 1'b0; rd = 1'b0; lsr_rd = 1'b0; fifo_clr = 1'b0; brcx16 = 1'b0;
        fifo_en = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; brcx16 = 1'b0; rx_d_rdy = 1'b0; rx_d = 8'h00;
        rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0; num_bits = 8; parity_en = 1'b0;
        fifo_en = 1'b1; fifo_clr = 1'b0; trig_sel = 2'b11; rd = 1'b0; lsr_rd = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_trigger();
        test_overrun();
        test_error_flags();
        test_timeout();
        test_non_fifo();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
